// File: rtl/wb_pl_sram.sv
// wb_pl_sram: pipelined Wishbone responder in front of a single-port data RAM,
// with sub-word lane alignment, error detection and configurable wait states.
module wb_pl_sram #(
    parameter int          DEPTH = 1024,
    parameter logic [31:0] BASE  = 32'h0000_0000,
    parameter int          WAIT  = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cyc,
    input  logic        i_stb,
    input  logic        i_we,
    input  logic [3:0]  i_sel,
    input  logic [31:0] i_adr,
    input  logic [31:0] i_dat_mo,
    output logic        o_ack,
    output logic        o_err,
    output logic        o_stall,
    output logic [31:0] o_dat_so
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0] r_mem [DEPTH];
    logic        r_resp_v;
    logic        r_resp_err;
    logic [2:0]  r_cnt;
    logic        r_pend_rd;
    logic [31:0] r_rbuf;
    logic [31:0] r_dat_so;

    logic          w_accept;
    logic [31:0]   w_off;
    logic          w_in_range;
    logic          w_sel_ok;
    logic [6:0]    w_lane;
    logic          w_err;
    logic          w_wr;
    logic          w_rd_ok;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_wdat;
    logic [31:0]   w_rdat;
    logic [31:0]   w_mask;

    always_comb begin
        w_accept   = i_cyc && i_stb && !o_stall;
        w_off      = i_adr - BASE;
        w_in_range = w_off < 32'(DEPTH * 4);
        w_sel_ok   = (i_sel == 4'b0001) || (i_sel == 4'b0011) || (i_sel == 4'b1111);
        w_lane     = {3'b000, i_sel} << i_adr[1:0];
        // Any lane pushed past byte 3 means the access straddles a word.
        w_err      = !w_sel_ok || (|w_lane[6:4]) || !w_in_range;
        w_wr       = w_accept && i_rst && i_we && !w_err;
        w_rd_ok    = !i_we && !w_err;
        w_idx      = w_off[AW+1:2];
        w_wdat     = i_dat_mo << {i_adr[1:0], 3'b000};
        w_mask     = {{8{i_sel[3]}}, {8{i_sel[2]}}, {8{i_sel[1]}}, {8{i_sel[0]}}};
        w_rdat     = (r_mem[w_idx] >> {i_adr[1:0], 3'b000}) & w_mask;
    end

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < 4; i++)
            if (w_wr && w_lane[i]) r_mem[w_idx][8*i +: 8] <= w_wdat[8*i +: 8];
        if (w_accept) r_rbuf <= w_rdat;
    end

    // With wait states the read data is parked in r_rbuf and only lands on
    // dat_so in the response cycle, so dat_so holds the previous read until then.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_resp_v   <= 1'b0;
            r_resp_err <= 1'b0;
            r_cnt      <= 3'd0;
            r_pend_rd  <= 1'b0;
            r_dat_so   <= 32'd0;
        end else if (!i_cyc) begin
            r_resp_v  <= 1'b0;
            r_cnt     <= 3'd0;
            r_pend_rd <= 1'b0;
        end else if (w_accept) begin
            r_resp_err <= w_err;
            r_resp_v   <= (WAIT == 0);
            r_cnt      <= 3'(WAIT);
            r_pend_rd  <= (WAIT != 0) && w_rd_ok;
            if (WAIT == 0 && w_rd_ok) r_dat_so <= w_rdat;
        end else begin
            r_resp_v  <= (r_cnt == 3'd1);
            r_pend_rd <= r_pend_rd && (r_cnt > 3'd1);
            if (r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
            if (r_cnt == 3'd1 && r_pend_rd) r_dat_so <= r_rbuf;
        end
    end

    always_comb begin
        o_stall  = r_cnt != 3'd0;
        o_ack    = r_resp_v && !r_resp_err && i_cyc;
        o_err    = r_resp_v && r_resp_err && i_cyc;
        o_dat_so = r_dat_so;
    end
endmodule
